// File: rtl/stack_ctl_pkg.sv
// Shared definitions for the stack controller: opcodes and FSM state encodings.
package stack_ctl_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_OVER = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;
  localparam logic [2:0] OP_REPL = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SW_REPL = 2'd1,
    ST_SW_PUSH = 2'd2
  } state_t;

endpackage

// File: rtl/stack_ctl_lifo.sv
// Operand stack storage: a shift-register LIFO with the top element in slot 0.
// Push and pop together overwrite the top in place. Contents are never reset.
module lifo
  import stack_ctl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 12
) (
  input  logic             i_clk,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_s0,
  output logic [WIDTH-1:0] o_s1
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Shift the whole stack down on push, up on pop, or rewrite the top on replace.
  always_ff @(posedge i_clk) begin
    if (i_push && i_pop) begin
      r_mem[0] <= i_data;
    end else if (i_push) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end else if (i_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        r_mem[i] <= r_mem[i+1];
      end
    end
  end

  assign o_s0 = r_mem[0];
  assign o_s1 = r_mem[1];

endmodule

// File: rtl/stack_ctl.sv
// Stack-machine operation sequencer: turns one accepted opcode into lifo
// push/pop cycles, tracks depth, and flags operations that would over/underflow.
// SWAP runs as pop, replace, push using two temp registers.
module stack_ctl
  import stack_ctl_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 12,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_s0,
  output logic [WIDTH-1:0] o_s1,
  output logic [DW-1:0]    o_depth,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_err,
  output logic             o_ovf,
  output logic             o_unf
);

  localparam logic [DW-1:0] L_ONE  = DW'(1);
  localparam logic [DW-1:0] L_TWO  = DW'(2);
  localparam logic [DW-1:0] L_FULL = DW'(DEPTH);

  state_t           r_state;
  state_t           w_nextState;
  logic [DW-1:0]    r_depth;
  logic [DW-1:0]    w_depthNext;
  logic [WIDTH-1:0] r_t0;
  logic [WIDTH-1:0] r_t1;
  logic             r_err;
  logic             r_ovf;
  logic             r_unf;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_lifoData;
  logic             w_illegal;
  logic             w_setOvf;
  logic             w_setUnf;
  logic             w_clear;
  logic             w_latchTmp;
  logic [WIDTH-1:0] w_s0;
  logic [WIDTH-1:0] w_s1;

  lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .i_clk  (i_clk),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (w_lifoData),
    .o_s0   (w_s0),
    .o_s1   (w_s1)
  );

  // Decode the accepted request (or the current SWAP step) into lifo controls, depth and flag updates.
  always_comb begin
    w_nextState = r_state;
    w_depthNext = r_depth;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_lifoData  = i_data;
    w_illegal   = 1'b0;
    w_setOvf    = 1'b0;
    w_setUnf    = 1'b0;
    w_clear     = 1'b0;
    w_latchTmp  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          case (i_op)
            OP_PUSH: begin
              if (r_depth < L_FULL) begin
                w_push      = 1'b1;
                w_depthNext = r_depth + L_ONE;
              end else begin
                w_illegal = 1'b1;
                w_setOvf  = 1'b1;
              end
            end
            OP_DUP: begin
              if (r_depth == '0) begin
                w_illegal = 1'b1;
                w_setUnf  = 1'b1;
              end else if (r_depth == L_FULL) begin
                w_illegal = 1'b1;
                w_setOvf  = 1'b1;
              end else begin
                w_push      = 1'b1;
                w_lifoData  = w_s0;
                w_depthNext = r_depth + L_ONE;
              end
            end
            OP_OVER: begin
              if (r_depth < L_TWO) begin
                w_illegal = 1'b1;
                w_setUnf  = 1'b1;
              end else if (r_depth == L_FULL) begin
                w_illegal = 1'b1;
                w_setOvf  = 1'b1;
              end else begin
                w_push      = 1'b1;
                w_lifoData  = w_s1;
                w_depthNext = r_depth + L_ONE;
              end
            end
            OP_DROP: begin
              if (r_depth == '0) begin
                w_illegal = 1'b1;
                w_setUnf  = 1'b1;
              end else begin
                w_pop       = 1'b1;
                w_depthNext = r_depth - L_ONE;
              end
            end
            OP_REPL: begin
              if (r_depth == '0) begin
                w_illegal = 1'b1;
                w_setUnf  = 1'b1;
              end else begin
                w_push = 1'b1;
                w_pop  = 1'b1;
              end
            end
            OP_SWAP: begin
              if (r_depth < L_TWO) begin
                w_illegal = 1'b1;
                w_setUnf  = 1'b1;
              end else begin
                w_latchTmp  = 1'b1;
                w_pop       = 1'b1;
                w_nextState = ST_SW_REPL;
              end
            end
            OP_CLR: begin
              w_clear     = 1'b1;
              w_depthNext = '0;
            end
            default: begin
            end
          endcase
        end
      end
      ST_SW_REPL: begin
        w_push      = 1'b1;
        w_pop       = 1'b1;
        w_lifoData  = r_t0;
        w_nextState = ST_SW_PUSH;
      end
      ST_SW_PUSH: begin
        w_push      = 1'b1;
        w_lifoData  = r_t1;
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State, depth and error flags; reset aborts any SWAP in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_depth <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_depth <= w_depthNext;
      r_err   <= w_illegal;
      r_ovf   <= w_clear ? 1'b0 : (r_ovf | w_setOvf);
      r_unf   <= w_clear ? 1'b0 : (r_unf | w_setUnf);
    end
  end

  // Capture the top two elements when a SWAP starts; they are replayed in the later steps.
  always_ff @(posedge i_clk) begin
    if (w_latchTmp) begin
      r_t0 <= w_s0;
      r_t1 <= w_s1;
    end
  end

  assign o_ready = (r_state == ST_IDLE);
  assign o_s0    = w_s0;
  assign o_s1    = w_s1;
  assign o_depth = r_depth;
  assign o_empty = (r_depth == '0);
  assign o_full  = (r_depth == L_FULL);
  assign o_err   = r_err;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

endmodule

// File: tb/tb_stack_ctl.sv
// Self-checking bench for stack_ctl: a reference stack model pushes the expected
// post-operation state into a queue as each request is driven; it is popped and
// compared against the DUT on the following falling edge.
module tb_stack_ctl;

  localparam logic [2:0] T_NOP  = 3'd0;
  localparam logic [2:0] T_PUSH = 3'd1;
  localparam logic [2:0] T_DROP = 3'd2;
  localparam logic [2:0] T_DUP  = 3'd3;
  localparam logic [2:0] T_OVER = 3'd4;
  localparam logic [2:0] T_SWAP = 3'd5;
  localparam logic [2:0] T_REPL = 3'd6;
  localparam logic [2:0] T_CLR  = 3'd7;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic [7:0] operand = 8'h00;
  logic       ready;
  logic [7:0] s0;
  logic [7:0] s1;
  logic [3:0] depth;
  logic       empty;
  logic       full;
  logic       err;
  logic       ovf;
  logic       unf;

  typedef struct {
    logic [7:0] s0;
    logic [7:0] s1;
    int         depth;
    logic       err;
    logic       ovf;
    logic       unf;
  } expected_t;

  expected_t  expQ[$];
  string      tagQ[$];
  logic [7:0] model[12];
  int         modelDepth = 0;
  logic       modelOvf = 1'b0;
  logic       modelUnf = 1'b0;
  int         checks = 0;
  int         failures = 0;

  stack_ctl #(
    .WIDTH (8),
    .DEPTH (12)
  ) dut (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_valid (valid),
    .o_ready (ready),
    .i_op    (opcode),
    .i_data  (operand),
    .o_s0    (s0),
    .o_s1    (s1),
    .o_depth (depth),
    .o_empty (empty),
    .o_full  (full),
    .o_err   (err),
    .o_ovf   (ovf),
    .o_unf   (unf)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelPush(input logic [7:0] value);
    for (int i = 11; i > 0; i--) model[i] = model[i-1];
    model[0] = value;
    modelDepth++;
  endtask

  task automatic modelPop();
    for (int i = 0; i < 11; i++) model[i] = model[i+1];
    modelDepth--;
  endtask

  task automatic modelReset();
    modelDepth = 0;
    modelOvf   = 1'b0;
    modelUnf   = 1'b0;
  endtask

  task automatic modelOp(input logic [2:0] op, input logic [7:0] value,
                         output logic errNow, output logic swapBusy);
    logic [7:0] a;
    logic [7:0] b;
    errNow   = 1'b0;
    swapBusy = 1'b0;
    case (op)
      T_PUSH: if (modelDepth < 12) modelPush(value);
              else begin errNow = 1'b1; modelOvf = 1'b1; end
      T_DUP:  if (modelDepth == 0) begin errNow = 1'b1; modelUnf = 1'b1; end
              else if (modelDepth == 12) begin errNow = 1'b1; modelOvf = 1'b1; end
              else modelPush(model[0]);
      T_OVER: if (modelDepth < 2) begin errNow = 1'b1; modelUnf = 1'b1; end
              else if (modelDepth == 12) begin errNow = 1'b1; modelOvf = 1'b1; end
              else modelPush(model[1]);
      T_DROP: if (modelDepth == 0) begin errNow = 1'b1; modelUnf = 1'b1; end
              else modelPop();
      T_REPL: if (modelDepth == 0) begin errNow = 1'b1; modelUnf = 1'b1; end
              else model[0] = value;
      T_SWAP: if (modelDepth < 2) begin errNow = 1'b1; modelUnf = 1'b1; end
              else begin
                a = model[0];
                b = model[1];
                model[0] = b;
                model[1] = a;
                swapBusy = 1'b1;
              end
      T_CLR:  modelReset();
      default: ;
    endcase
  endtask

  task automatic queueExpected(input string tag, input logic errNow);
    expected_t e;
    e.s0    = model[0];
    e.s1    = model[1];
    e.depth = modelDepth;
    e.err   = errNow;
    e.ovf   = modelOvf;
    e.unf   = modelUnf;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic compareNext();
    expected_t e;
    string     tag;
    e   = expQ.pop_front();
    tag = tagQ.pop_front();
    checkOutput({tag, ".ready"}, {31'd0, ready}, 32'd1);
    checkOutput({tag, ".depth"}, {28'd0, depth}, e.depth);
    checkOutput({tag, ".empty"}, {31'd0, empty}, {31'd0, e.depth == 0});
    checkOutput({tag, ".full"},  {31'd0, full},  {31'd0, e.depth == 12});
    checkOutput({tag, ".err"},   {31'd0, err},   {31'd0, e.err});
    checkOutput({tag, ".ovf"},   {31'd0, ovf},   {31'd0, e.ovf});
    checkOutput({tag, ".unf"},   {31'd0, unf},   {31'd0, e.unf});
    if (e.depth >= 1) checkOutput({tag, ".s0"}, {24'd0, s0}, {24'd0, e.s0});
    if (e.depth >= 2) checkOutput({tag, ".s1"}, {24'd0, s1}, {24'd0, e.s1});
  endtask

  // Drives one request at a falling edge and leaves valid high so calls chain back-to-back.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [7:0] value);
    logic errNow;
    logic swapBusy;
    valid   = 1'b1;
    opcode  = op;
    operand = value;
    modelOp(op, value, errNow, swapBusy);
    queueExpected(tag, errNow);
    if (swapBusy) begin
      @(negedge clock);
      checkOutput({tag, ".busy1"}, {31'd0, ready}, 32'd0);
      opcode  = T_PUSH;
      operand = 8'hEE;
      @(negedge clock);
      checkOutput({tag, ".busy2"}, {31'd0, ready}, 32'd0);
    end
    @(negedge clock);
    compareNext();
  endtask

  task automatic idleCycle(input string tag);
    valid = 1'b0;
    queueExpected(tag, 1'b0);
    @(negedge clock);
    compareNext();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    modelReset();
    idleCycle("reset");

    applyStimulus("push11", T_PUSH, 8'h11);
    applyStimulus("push22", T_PUSH, 8'h22);
    applyStimulus("push33", T_PUSH, 8'h33);

    applyStimulus("swap", T_SWAP, 8'h00);
    applyStimulus("drop1", T_DROP, 8'h00);
    applyStimulus("drop2", T_DROP, 8'h00);

    applyStimulus("repl22", T_REPL, 8'h22);
    applyStimulus("dup", T_DUP, 8'h00);
    applyStimulus("over", T_OVER, 8'h00);
    applyStimulus("repl7f", T_REPL, 8'h7F);
    applyStimulus("nop", T_NOP, 8'h55);
    idleCycle("afterRepl");

    applyStimulus("clrFill", T_CLR, 8'h00);
    for (int i = 0; i < 12; i++) applyStimulus("fill", T_PUSH, 8'(8'hA0 + i));
    applyStimulus("pushOvf", T_PUSH, 8'hAA);
    idleCycle("errPulseEnd");
    applyStimulus("dupFull", T_DUP, 8'h00);
    applyStimulus("overFull", T_OVER, 8'h00);
    applyStimulus("dropFull", T_DROP, 8'h00);
    idleCycle("afterFull");

    applyStimulus("clrEmpty", T_CLR, 8'h00);
    applyStimulus("dropEmpty", T_DROP, 8'h00);
    applyStimulus("swapEmpty", T_SWAP, 8'h00);
    applyStimulus("replEmpty", T_REPL, 8'h44);
    applyStimulus("dupEmpty", T_DUP, 8'h00);
    applyStimulus("push05", T_PUSH, 8'h05);
    applyStimulus("overOne", T_OVER, 8'h00);
    applyStimulus("swapOne", T_SWAP, 8'h00);
    applyStimulus("clrFlags", T_CLR, 8'h00);
    idleCycle("afterClr");

    applyStimulus("dropPre", T_DROP, 8'h00);
    applyStimulus("pushA", T_PUSH, 8'h01);
    applyStimulus("pushB", T_PUSH, 8'h02);
    opcode = T_SWAP;
    @(negedge clock);
    checkOutput("midSwap.busy", {31'd0, ready}, 32'd0);
    valid = 1'b0;
    reset = 1'b1;
    modelReset();
    queueExpected("midSwapReset", 1'b0);
    @(negedge clock);
    compareNext();
    reset = 1'b0;
    idleCycle("afterReset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_ctl.md
# stack_ctl

Sequencing controller for the 12-deep `lifo` operand stack. It accepts one stack-machine operation per handshake and translates it into `lifo` push/pop/replace cycles: single-cycle PUSH/DROP/DUP/OVER/REPL/CLR and a multi-cycle SWAP. It tracks stack depth and rejects operations that would underflow or overflow, reporting errors. It sits between the instruction decoder and the stack datapath; the decoder only sees a ready/valid operation port and the top two stack values.

## Interface
- `WIDTH`, 8: bits per stack element.
- `DEPTH`, 12: stack capacity. Must equal the `lifo` depth (12).
- `DW`, `$clog2(DEPTH+1)`: depth-counter width (localparam).

Ports:
- `i_clk` in 1: system clock. One clock domain.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_valid` in 1: operation request.
- `o_ready` out 1: controller can accept an operation. Reset value 1.
- `i_op` in 3: opcode. 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 OVER, 5 SWAP, 6 REPL, 7 CLR.
- `i_data` in WIDTH: operand for PUSH and REPL.
- `o_s0` out WIDTH: top of stack. Meaningful only when depth ≥ 1.
- `o_s1` out WIDTH: next on stack. Meaningful only when depth ≥ 2.
- `o_depth` out DW: current element count. Reset value 0.
- `o_empty` out 1: depth == 0. Reset value 1.
- `o_full` out 1: depth == DEPTH. Reset value 0.
- `o_err` out 1: one-cycle pulse marking a rejected operation. Reset value 0.
- `o_ovf` out 1: sticky overflow flag. Reset value 0.
- `o_unf` out 1: sticky underflow flag. Reset value 0.

## Operation
- An operation is accepted on a rising edge where `i_valid && o_ready`. The opcode and operand are sampled at that edge only.
- Legality checks use the depth `d` before the operation. An illegal operation is still accepted but causes no stack or depth change.
  - PUSH: needs d < DEPTH. Illegal sets `o_ovf`.
  - DUP: needs 1 ≤ d < DEPTH. Sets `o_unf` if d = 0, `o_ovf` if d = DEPTH.
  - OVER: needs 2 ≤ d < DEPTH. Sets `o_unf` if d < 2, `o_ovf` if d = DEPTH.
  - DROP: needs d ≥ 1. Illegal sets `o_unf`.
  - REPL: needs d ≥ 1. Illegal sets `o_unf`.
  - SWAP: needs d ≥ 2. Illegal sets `o_unf`.
  - NOP and CLR are always legal.
  - Any illegal operation also pulses `o_err`.
- Effects of legal operations:
  - PUSH: push `i_data`, d+1.
  - DUP: push s0, d+1.
  - OVER: push s1, d+1.
  - DROP: pop, d−1.
  - REPL: push and pop together with `i_data`, so s0 is replaced; d unchanged.
  - CLR: d←0 and clears `o_ovf`/`o_unf`. Stack contents are left as-is and become don't-care.
- FSM states: IDLE, SW_REPL, SW_PUSH.
  - IDLE: `o_ready`=1. `lifo` controls are driven combinationally from the accepted request, so the stack updates on the accept edge.
  - SWAP accepted in IDLE with d ≥ 2: latch t0=s0 and t1=s1, issue pop, go to SW_REPL.
  - SW_REPL: replace s0 with t0, go to SW_PUSH.
  - SW_PUSH: push t1, go to IDLE.
  - Resulting stack is [t1, t0, s2, …]. Depth is unchanged over the whole sequence; `o_depth` never glitches.
  - `o_ready`=0 in SW_REPL and SW_PUSH. Requests are ignored and not queued.
- Reset:
  - Forces IDLE, depth 0, all flags cleared, `o_err` 0.
  - Applies mid-SWAP: the sequence aborts and stack contents become don't-care.
  - `lifo` contents themselves are not reset.

## Timing
- Single-cycle operations: `o_s0`/`o_s1`/`o_depth` reflect the operation in the cycle after the accept edge. Back-to-back acceptance every cycle is allowed.
- SWAP: 3 cycles. `o_ready` is low for the 2 cycles after acceptance. The final stack is visible on the cycle `o_ready` returns to 1.
- `o_err`, `o_ovf`, `o_unf` are registered and assert the cycle after the accept edge of the illegal operation.
- `o_empty` and `o_full` are derived from the registered depth. They have no extra latency relative to `o_depth`.

## Structure
- Shared package holds:
  - opcode constants: `OP_NOP`, `OP_PUSH`, `OP_DROP`, `OP_DUP`, `OP_OVER`, `OP_SWAP`, `OP_REPL`, `OP_CLR`;
  - FSM state encodings.
- One sub-module: `lifo`, instantiated with the same WIDTH/DEPTH. Its `o_s0`/`o_s1` are forwarded directly to the ports.
- Control path consists of the FSM, the depth counter, temp registers t0/t1, and the flag logic.

## Test plan
- Reset, then PUSH 0x11, 0x22, 0x33 on consecutive cycles → s0=0x33, s1=0x22, depth=3, `o_ready` held at 1.
- From [0x33,0x22,0x11], SWAP → `o_ready` low 2 cycles, then s0=0x22, s1=0x33, depth=3. A following DROP, DROP leaves s0=0x11.
- From [0x22], DUP then OVER → [0x22,0x22,0x22], depth=3. REPL 0x7F → s0=0x7F, s1=0x22, depth=3.
- Push 12 values, then PUSH 0xAA → `o_err` pulses once, `o_ovf`=1, depth=12, s0 unchanged, `o_full`=1.
- From empty, DROP and SWAP → two `o_err` pulses, `o_unf`=1, depth=0. CLR → both sticky flags clear.
- Assert `i_rst` in SW_REPL → next cycle IDLE, `o_ready`=1, depth=0, `o_empty`=1, all flags 0.
